link_tx_scheduler: RTL

// Frame scheduler in front of the four-phase sender on the clk_sender side. Arbitrates N_SRC

---
 rtl/link_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/link_tx_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared constants, state encoding and sizing helpers
// for the link transmit scheduler.
package link_pkg;

  localparam logic [2:0] IDLE_SRC = 3'd7;

  typedef enum logic [1:0] {
    LINK_RST,
    LOAD,
    STREAM
  } link_state_e;

  // One header handshake plus one per nibble.
  function automatic int hs_per_frame(input int n_bits);
    return 1 + (n_bits + 3) / 4;
  endfunction

  function automatic int cnt_w(input int n_bits);
    int w;
    w = $clog2(hs_per_frame(n_bits));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after ptr wins, wrapping at N_SRC.
module rr_arbiter
  import link_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [2:0]       idx,
  output logic             any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = IDLE_SRC;
    any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      j = (int'(ptr) + k) % N_SRC;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = 3'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin frame scheduler feeding the four-phase
// sender; tracks frame boundaries and sequences its reset.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int N_BITS  = 1500,
  parameter int N_SRC   = 3,
  parameter int RST_CYC = 4
) (
  input  logic                    clk_sender,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*N_BITS-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  input  logic                    resync_req,
  input  logic                    wire_ack,
  output logic [N_BITS-1:0]       tx_data,
  output logic [2:0]              tx_src,
  output logic                    sender_rst,
  output logic                    frame_done
);

  localparam int HS    = hs_per_frame(N_BITS);
  localparam int CNT_W = cnt_w(N_BITS);
  localparam int RST_W = $clog2(RST_CYC);

  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HS - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);

  link_state_e       state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  hs_cnt_q, hs_cnt_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [N_BITS-1:0] tx_data_q, tx_data_d;
  logic [2:0]        tx_src_q, tx_src_d;
  logic [N_SRC-1:0]  src_ready_q, src_ready_d;
  logic              ack_s1_q, ack_s2_q;
  logic              ack_rise;

  logic [N_SRC-1:0]  gnt;
  logic [2:0]        win_idx;
  logic              win_any;

  rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req (src_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign ack_rise = ack_s1_q & ~ack_s2_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    hs_cnt_d    = hs_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    tx_src_d    = tx_src_q;
    src_ready_d = '0;
    frame_done  = 1'b0;
    unique case (state_q)
      LINK_RST: begin
        hs_cnt_d  = '0;
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        state_d = STREAM;
        if (win_any) begin
          tx_data_d   = src_data[int'(win_idx)*N_BITS +: N_BITS];
          tx_src_d    = win_idx;
          src_ready_d = gnt;
          rr_ptr_d    = (int'(win_idx) == N_SRC - 1) ?
                        3'd0 : win_idx + 3'd1;
        end else begin
          tx_data_d = '0;
          tx_src_d  = IDLE_SRC;
        end
      end
      STREAM: begin
        if (ack_rise) begin
          if (hs_cnt_q == HS_LAST) begin
            hs_cnt_d   = '0;
            frame_done = 1'b1;
            state_d    = LOAD;
          end else begin
            hs_cnt_d = hs_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LINK_RST;
    endcase
    // Resync overrides whatever the current state decided.
    if (resync_req) begin
      state_d     = LINK_RST;
      rst_cnt_d   = '0;
      hs_cnt_d    = '0;
      rr_ptr_d    = rr_ptr_q;
      tx_data_d   = tx_data_q;
      tx_src_d    = tx_src_q;
      src_ready_d = '0;
      frame_done  = 1'b0;
    end
  end

  always_ff @(posedge clk_sender or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LINK_RST;
      rst_cnt_q   <= '0;
      hs_cnt_q    <= '0;
      rr_ptr_q    <= '0;
      tx_data_q   <= '0;
      tx_src_q    <= IDLE_SRC;
      src_ready_q <= '0;
      ack_s1_q    <= 1'b0;
      ack_s2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      hs_cnt_q    <= hs_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      tx_src_q    <= tx_src_d;
      src_ready_q <= src_ready_d;
      ack_s1_q    <= wire_ack;
      ack_s2_q    <= ack_s1_q;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_src     = tx_src_q;
  assign src_ready  = src_ready_q;
  assign sender_rst = (state_q == LINK_RST);

endmodule
